// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/add_sub_nbit.sv
// Combinational N-bit adder/subtractor: sum = a + b, or a - b when sub is set.
module add_sub_nbit #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  // Two's-complement subtract: invert b and inject the carry-in.
  assign sum = a + (b ^ {N{sub}}) + N'(sub);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one add/shift pair per multiplier bit, product in {A,B},
// with an extension bit X holding the sign (signed mode) or the add carry (unsigned mode).
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned EW = WIDTH + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             mode_q, mode_d;
  logic             run_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [EW-1:0]    op_a, op_b, sum;
  logic             sub;
  logic             run_edge;
  logic             last_iter;

  assign run_edge  = Run & ~run_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Operands widened by one bit: sign-extended in signed mode, zero-extended otherwise.
  assign op_a = {mode_q & a_q[WIDTH-1], a_q};
  assign op_b = {mode_q & mcand_q[WIDTH-1], mcand_q};
  assign sub  = mode_q & last_iter;

  add_sub_nbit #(.N(EW)) u_add_sub (
    .a   (op_a),
    .b   (op_b),
    .sub (sub),
    .sum (sum)
  );

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      run_q   <= Run;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A load wins over a coincident Run edge; that edge is consumed and lost.
        if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end else if (run_edge) begin
          state_d = START;
        end
      end
      START: begin
        a_d     = '0;
        x_d     = 1'b0;
        mcand_d = S;
        mode_d  = Signed;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        {x_d, a_d, b_d} = {mode_q & x_q, x_q, a_q, b_q[WIDTH-1:1]};
        cnt_d           = cnt_q + CW'(1);
        state_d         = last_iter ? DONE : ADD;
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == START) || (state_d == ADD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised self-checking bench for shift_add_multiplier (WIDTH=8 and WIDTH=4 instances).
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;

  logic       run8, cl8, sg8;
  logic [7:0] s8, a8, b8;
  logic       x8, busy8, done8;

  logic       run4, cl4, sg4;
  logic [3:0] s4, a4, b4;
  logic       x4, busy4, done4;

  int checks;
  int failures;

  logic [31:0] bexp8;
  logic [31:0] bexp4;

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .Run(run8), .ClearA_LoadB(cl8), .Signed(sg8),
    .S(s8), .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
  );

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset_n(rst_n), .Run(run4), .ClearA_LoadB(cl4), .Signed(sg4),
    .S(s4), .Aval(a4), .Bval(b4), .X(x4), .Busy(busy4), .Done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands as the mode interprets them.
  task automatic ref_mul(input int w, input logic [31:0] b, input logic [31:0] s, input bit sg,
                         output logic [63:0] p, output logic x);
    longint bb, ss, pr, one;
    one = 1;
    bb  = longint'({32'b0, b}) & ((one << w) - 1);
    ss  = longint'({32'b0, s}) & ((one << w) - 1);
    if (sg && b[w-1]) bb = bb - (one << w);
    if (sg && s[w-1]) ss = ss - (one << w);
    pr = bb * ss;
    p  = 64'(pr) & 64'((one << (2 * w)) - 1);
    x  = sg && (pr < 0);
  endtask

  task automatic set_in(input bit w4, input logic run, input logic cl, input logic sg,
                        input logic [7:0] s);
    if (w4) begin
      run4 = run; cl4 = cl; sg4 = sg; s4 = s[3:0];
    end else begin
      run8 = run; cl8 = cl; sg8 = sg; s8 = s;
    end
  endtask

  task automatic set_cl(input bit w4, input logic cl, input logic [7:0] s);
    if (w4) begin
      cl4 = cl; s4 = s[3:0];
    end else begin
      cl8 = cl; s8 = s;
    end
  endtask

  function automatic logic [63:0] prod(input bit w4);
    return w4 ? 64'({a4, b4}) : 64'({a8, b8});
  endfunction

  function automatic logic xo(input bit w4);
    return w4 ? x4 : x8;
  endfunction

  function automatic logic busy(input bit w4);
    return w4 ? busy4 : busy8;
  endfunction

  function automatic logic done(input bit w4);
    return w4 ? done4 : done8;
  endfunction

  task automatic load(input bit w4, input logic [7:0] b);
    @(negedge clk);
    set_in(w4, 1'b0, 1'b1, 1'b0, b);
    @(negedge clk);
    set_in(w4, 1'b0, 1'b0, 1'b0, b);
    if (w4) begin
      bexp4 = 32'(b[3:0]);
      check("load_b4", 64'(b4), 64'(b[3:0]));
    end else begin
      bexp8 = 32'(b);
      check("load_b8", 64'(b8), 64'(b));
    end
  endtask

  // One multiply: checks start Busy, Done latency, product, X, Busy after completion.
  task automatic run_op(input bit w4, input logic [7:0] s, input bit sg, input string tag,
                        input int hold, input bit midclr);
    int          w, n, extra;
    bit          seen, busy_seen;
    logic [63:0] ep;
    logic        ex;
    w = w4 ? 4 : 8;
    ref_mul(w, w4 ? bexp4 : bexp8, 32'(s), sg, ep, ex);
    @(negedge clk);
    set_in(w4, 1'b1, 1'b0, sg, s);
    n = 0; seen = 0; busy_seen = 0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) busy_seen = busy(w4);
      if (midclr && n == 5) set_cl(w4, 1'b1, 8'($urandom));
      if (midclr && n == 6) set_cl(w4, 1'b0, s);
      if (done(w4)) seen = 1;
    end
    check($sformatf("%s_busy_start", tag), 64'(busy_seen), 64'(1));
    check($sformatf("%s_latency", tag), 64'(n), 64'(2 * w + 2));
    check($sformatf("%s_product", tag), prod(w4), ep);
    check($sformatf("%s_x", tag), 64'(xo(w4)), 64'(ex));
    check($sformatf("%s_busy_done", tag), 64'(busy(w4)), 64'(0));
    if (w4) bexp4 = 32'(ep[3:0]);
    else    bexp8 = 32'(ep[7:0]);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (done(w4)) extra++;
      if (busy(w4)) extra++;
    end
    if (hold > 0) begin
      check($sformatf("%s_hold_quiet", tag), 64'(extra), 64'(0));
      check($sformatf("%s_hold_product", tag), prod(w4), ep);
    end
    @(negedge clk);
    set_in(w4, 1'b0, 1'b0, sg, s);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   busy_cnt;
    bit   w4r;
    logic [7:0] rb, rs;
    checks = 0; failures = 0;
    bexp8 = '0; bexp4 = '0;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_a", 64'(a8), 64'(0));
    check("rst_b", 64'(b8), 64'(0));
    check("rst_x", 64'(x8), 64'(0));
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_done", 64'(done8), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    load(1'b0, 8'h07); run_op(1'b0, 8'h03, 1'b1, "s_7x3", 0, 0);
    load(1'b0, 8'hF9); run_op(1'b0, 8'hFD, 1'b1, "s_m7xm3", 0, 0);
    load(1'b0, 8'h80); run_op(1'b0, 8'h80, 1'b1, "s_minxmin", 0, 0);
    load(1'b0, 8'h05); run_op(1'b0, 8'hFE, 1'b1, "s_5xm2", 0, 0);
    load(1'b0, 8'hFF); run_op(1'b0, 8'hFF, 1'b0, "u_ffxff", 0, 0);
    load(1'b0, 8'h00); run_op(1'b0, 8'hAB, 1'b0, "u_0xab", 0, 0);

    // Held Run: one Done only, then re-press reuses B (previous low half).
    load(1'b0, 8'h12); run_op(1'b0, 8'h34, 1'b0, "held", 20, 0);
    run_op(1'b0, 8'h03, 1'b0, "repress", 0, 0);

    // Load and Run edge together: load only.
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    bexp8 = 32'h3C;
    check("load_run_b", 64'(b8), 64'h3C);
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
    end
    check("load_run_nostart", 64'(busy_cnt), 64'(0));

    // Async reset mid-ADD.
    load(1'b0, 8'h5A);
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_a", 64'(a8), 64'(0));
    check("mid_rst_b", 64'(b8), 64'(0));
    check("mid_rst_x", 64'(x8), 64'(0));
    check("mid_rst_busy", 64'(busy8), 64'(0));
    check("mid_rst_done", 64'(done8), 64'(0));
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bexp8 = '0; bexp4 = '0;
    busy_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy8 || done8) busy_cnt++;
    end
    check("post_rst_idle", 64'(busy_cnt), 64'(0));

    // Load pulse while busy must not disturb the operation.
    load(1'b0, 8'h6B); run_op(1'b0, 8'hC5, 1'b1, "midclr", 0, 1);

    load(1'b1, 8'h07); run_op(1'b1, 8'h08, 1'b1, "w4_7xm8", 0, 0);

    for (int i = 0; i < 24; i++) begin
      w4r = 1'($urandom_range(0, 1));
      rb  = 8'($urandom);
      rs  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) load(w4r, rb);
      run_op(w4r, rs, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
